// File: rtl/pdua.sv
// pdua - datapath of the PDUA teaching processor.
//
// One micro-operation per clock, steered entirely by an external
// microsequencer. Contains the register bank, the ALU, an optional
// shifter, the C/N/P/Z flags, MAR, MDR, IR and an internal data memory.
//
// Build option:
//   PDUA_SHIFTER_EN  defined   -> shifter present (shamt 01 = SLL, 10 = SRL)
//                    undefined -> shamt ignored, S = Y, carry from the ALU only
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   wr_rdn                memory direction (1 = write mem[MAR] <= MDR)
//   enaf                  load C/N/P/Z from the shifter output
//   selop[2:0]            ALU operation (a = ACC, b = bus B)
//   shamt[1:0]            shifter control
//   C, N, P, Z            registered flags
//   bank_wr_en            write bus C into bank[BusC_addr]
//   BusB_addr, BusC_addr  bus B source / bus C destination register
//   sclr                  synchronous clear of MAR, MDR, IR and flags
//   ir_en, mar_en, mdr_en load enables
//   mdr_alu_n             bus C source (1 = MDR, 0 = shifter)
//   out_IR[4:0]           opcode field of IR
//
// Register map: 0 PC, 1 SP, 2 DPTR, 3 A, 4 VI, 5 ONE (constant 1), 6 TEMP, 7 ACC.
module pdua #(
  parameter int MAX_WIDTH  = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_rdn,
  input  logic                  enaf,
  input  logic [2:0]            selop,
  input  logic [1:0]            shamt,
  output logic                  C,
  output logic                  N,
  output logic                  P,
  output logic                  Z,
  input  logic                  bank_wr_en,
  input  logic [ADDR_WIDTH-1:0] BusB_addr,
  input  logic [ADDR_WIDTH-1:0] BusC_addr,
  input  logic                  sclr,
  input  logic                  ir_en,
  input  logic                  mar_en,
  input  logic                  mdr_en,
  input  logic                  mdr_alu_n,
  output logic [4:0]            out_IR
);

  localparam int NUM_REGS  = 1 << ADDR_WIDTH;
  localparam int MEM_DEPTH = 1 << MAX_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] REG_ONE = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] REG_ACC = ADDR_WIDTH'(7);

  logic [MAX_WIDTH-1:0] bank [NUM_REGS];
  logic [MAX_WIDTH-1:0] mem  [MEM_DEPTH];
  logic [MAX_WIDTH-1:0] mar, mdr, ir;

  logic [MAX_WIDTH-1:0] bus_a, bus_b, bus_c;
  logic [MAX_WIDTH-1:0] y, s;
  logic [MAX_WIDTH:0]   wide;
  logic                 alu_c, s_c;

  assign bus_a = bank[REG_ACC];
  assign bus_b = bank[BusB_addr];

  // ALU. Arithmetic ops run one bit wider so the top bit is the carry
  // (or, for subtraction, the borrow).
  always_comb begin
    y     = '0;
    alu_c = 1'b0;
    wide  = '0;
    case (selop)
      3'b000: y = bus_b;
      3'b001: y = ~bus_a;
      3'b010: y = bus_a & bus_b;
      3'b011: y = bus_a | bus_b;
      3'b100: y = bus_a ^ bus_b;
      3'b101: begin
        wide  = {1'b0, bus_a} + {1'b0, bus_b};
        y     = wide[MAX_WIDTH-1:0];
        alu_c = wide[MAX_WIDTH];
      end
      3'b110: begin
        wide  = {1'b0, bus_b} + (MAX_WIDTH+1)'(1);
        y     = wide[MAX_WIDTH-1:0];
        alu_c = wide[MAX_WIDTH];
      end
      default: begin
        wide  = {1'b0, bus_a} - {1'b0, bus_b};
        y     = wide[MAX_WIDTH-1:0];
        alu_c = wide[MAX_WIDTH];
      end
    endcase
  end

`ifdef PDUA_SHIFTER_EN
  // A shift replaces the ALU carry with the bit shifted out.
  always_comb begin
    s   = y;
    s_c = alu_c;
    case (shamt)
      2'b01: begin
        s   = {y[MAX_WIDTH-2:0], 1'b0};
        s_c = y[MAX_WIDTH-1];
      end
      2'b10: begin
        s   = {1'b0, y[MAX_WIDTH-1:1]};
        s_c = y[0];
      end
      default: ;
    endcase
  end
`else
  logic unused_shamt;
  assign unused_shamt = ^shamt;
  assign s   = y;
  assign s_c = alu_c;
`endif

  assign bus_c = mdr_alu_n ? mdr : s;

  // ONE is stored like any other register but can never be written, so it
  // holds the 1 loaded at reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        bank[i] <= (i == int'(REG_ONE)) ? MAX_WIDTH'(1) : '0;
    end else if (!sclr && bank_wr_en && (BusC_addr != REG_ONE)) begin
      bank[BusC_addr] <= bus_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || sclr) begin
      C   <= 1'b0;
      N   <= 1'b0;
      P   <= 1'b0;
      Z   <= 1'b0;
      mar <= '0;
      mdr <= '0;
      ir  <= '0;
    end else begin
      if (enaf) begin
        C <= s_c;
        N <= s[MAX_WIDTH-1];
        P <= ^s;
        Z <= (s == '0);
      end
      if (mar_en)
        mar <= bus_c;
      // On a write cycle memory captures the pre-edge MDR while MDR
      // itself takes bus C.
      if (mdr_en)
        mdr <= wr_rdn ? bus_c : mem[mar];
      if (ir_en)
        ir <= mdr;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && !sclr && wr_rdn)
      mem[mar] <= mdr;
  end

  assign out_IR = ir[MAX_WIDTH-1 -: 5];

endmodule

// File: tb/tb_pdua.sv
module tb_pdua;

  typedef struct packed {
    logic       rst;
    logic       sclr;
    logic [2:0] selop;
    logic [1:0] shamt;
    logic [2:0] busb;
    logic [2:0] busc;
    logic       bank_wr_en;
    logic       enaf;
    logic       mdr_alu_n;
    logic       mar_en;
    logic       mdr_en;
    logic       wr_rdn;
    logic       ir_en;
  } ctl_t;

  typedef struct packed {
    ctl_t       c;
    logic [3:0] exp_cnpz;
    logic [4:0] exp_ir;
  } vec_t;

`ifdef PDUA_SHIFTER_EN
  localparam bit SHIFTER_EN = 1'b1;
`else
  localparam bit SHIFTER_EN = 1'b0;
`endif

  logic       clk;
  logic       rst, wr_rdn, enaf, bank_wr_en, sclr, ir_en, mar_en, mdr_en, mdr_alu_n;
  logic [2:0] selop, BusB_addr, BusC_addr;
  logic [1:0] shamt;
  logic       C, N, P, Z;
  logic [4:0] out_IR;

  pdua #(.MAX_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .wr_rdn(wr_rdn), .enaf(enaf), .selop(selop),
    .shamt(shamt), .C(C), .N(N), .P(P), .Z(Z), .bank_wr_en(bank_wr_en),
    .BusB_addr(BusB_addr), .BusC_addr(BusC_addr), .sclr(sclr),
    .ir_en(ir_en), .mar_en(mar_en), .mdr_en(mdr_en),
    .mdr_alu_n(mdr_alu_n), .out_IR(out_IR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain integer arithmetic on the architectural state.
  int m_bank [8];
  int m_mem  [256];
  int m_mar, m_mdr, m_ir;
  bit m_c, m_n, m_p, m_z;

  function automatic bit parity8(input int v);
    int cnt = 0;
    for (int i = 0; i < 8; i++) if (((v >> i) & 1) == 1) cnt++;
    return bit'(cnt % 2);
  endfunction

  task automatic model_step(input ctl_t c);
    int a, b, yv, sv, busc, old_mdr, old_mar;
    bit car;
    if (c.rst) begin
      foreach (m_bank[i]) m_bank[i] = 0;
      m_bank[5] = 1;
      m_mar = 0; m_mdr = 0; m_ir = 0;
      {m_c, m_n, m_p, m_z} = 4'b0000;
    end else if (c.sclr) begin
      m_mar = 0; m_mdr = 0; m_ir = 0;
      {m_c, m_n, m_p, m_z} = 4'b0000;
    end else begin
      a = m_bank[7];
      b = m_bank[int'(c.busb)];
      car = 1'b0;
      case (int'(c.selop))
        0: yv = b;
        1: yv = 255 - a;
        2: yv = a & b;
        3: yv = a | b;
        4: yv = a ^ b;
        5: begin yv = (a + b) % 256; car = (a + b) > 255; end
        6: begin yv = (b + 1) % 256; car = (b + 1) > 255; end
        default: begin yv = (a - b + 256) % 256; car = a < b; end
      endcase
      sv = yv;
      if (SHIFTER_EN && c.shamt == 2'b01) begin sv = (yv * 2) % 256; car = yv >= 128; end
      if (SHIFTER_EN && c.shamt == 2'b10) begin sv = yv / 2; car = (yv % 2) == 1; end
      busc = c.mdr_alu_n ? m_mdr : sv;
      old_mdr = m_mdr;
      old_mar = m_mar;
      if (c.wr_rdn) m_mem[old_mar] = old_mdr;
      if (c.mdr_en) m_mdr = c.wr_rdn ? busc : m_mem[old_mar];
      if (c.bank_wr_en && c.busc != 3'd5) m_bank[int'(c.busc)] = busc;
      if (c.enaf) begin
        m_c = car;
        m_n = busc_sign(sv);
        m_p = parity8(sv);
        m_z = (sv == 0);
      end
      if (c.mar_en) m_mar = busc;
      if (c.ir_en) m_ir = old_mdr;
    end
  endtask

  function automatic bit busc_sign(input int v);
    return v >= 128;
  endfunction

  task automatic check_out(input string nm, input logic [3:0] exp_f, input logic [4:0] exp_ir);
    n_cmp++;
    if ({C, N, P, Z} !== exp_f || out_IR !== exp_ir) begin
      n_bad++;
      $display("FAIL %s: got CNPZ=%b out_IR=%b, expected CNPZ=%b out_IR=%b",
               nm, {C, N, P, Z}, out_IR, exp_f, exp_ir);
    end
  endtask

  function automatic logic [4:0] model_ir5();
    return 5'((m_ir >> 3) & 31);
  endfunction

  task automatic check_model(input string nm);
    check_out(nm, {m_c, m_n, m_p, m_z}, model_ir5());
  endtask

  task automatic drive(input ctl_t c);
    rst = c.rst; sclr = c.sclr; selop = c.selop; shamt = c.shamt;
    BusB_addr = c.busb; BusC_addr = c.busc; bank_wr_en = c.bank_wr_en;
    enaf = c.enaf; mdr_alu_n = c.mdr_alu_n; mar_en = c.mar_en;
    mdr_en = c.mdr_en; wr_rdn = c.wr_rdn; ir_en = c.ir_en;
  endtask

  // Drive one micro-op, clock it, update the model, sample at the falling edge.
  task automatic run(input ctl_t c);
    drive(c);
    @(posedge clk);
    model_step(c);
    @(negedge clk);
  endtask

  function automatic ctl_t op(input int sel, input int b, input int dst, input bit wr);
    ctl_t c;
    c = '0;
    c.selop = 3'(sel);
    c.busb = 3'(b);
    c.busc = 3'(dst);
    c.bank_wr_en = wr;
    c.enaf = 1'b1;
    return c;
  endfunction

  function automatic ctl_t rst_op();
    ctl_t c;
    c = '0;
    c.rst = 1'b1;
    return c;
  endfunction

  // Builds ACC = v from nothing but ONE, doubling and incrementing.
  task automatic load_acc(input int v);
    run(op(4, 7, 7, 1));
    for (int i = 7; i >= 0; i--) begin
      run(op(5, 7, 7, 1));
      check_model("load_acc_dbl");
      if (((v >> i) & 1) == 1) begin
        run(op(5, 5, 7, 1));
        check_model("load_acc_inc");
      end
    end
  endtask

  vec_t vecs [27];

  initial begin
    ctl_t c;
    foreach (m_mem[i]) m_mem[i] = 0;
    drive(rst_op());
    run(rst_op());
    run(rst_op());
    check_out("reset", 4'b0000, 5'd0);

    vecs[0]  = '{rst_op(),          4'b0000, 5'd0};
    vecs[1]  = '{op(1, 7, 7, 1),    4'b0100, 5'd0};  // ACC = FF
    vecs[2]  = '{op(1, 7, 7, 1),    4'b0001, 5'd0};  // ACC = 00
    vecs[3]  = '{op(0, 5, 7, 1),    4'b0010, 5'd0};  // ACC = 01
    vecs[4]  = '{op(5, 7, 7, 1),    4'b0010, 5'd0};  // 02, reads old ACC
    vecs[5]  = '{op(5, 7, 7, 1),    4'b0010, 5'd0};  // 04
    vecs[6]  = '{op(5, 7, 7, 1),    4'b0010, 5'd0};  // 08
    vecs[7]  = '{op(5, 7, 7, 1),    4'b0010, 5'd0};  // 10
    vecs[8]  = '{op(0, 7, 6, 1),    4'b0010, 5'd0};  // TEMP = 10
    vecs[9]  = '{op(4, 7, 7, 1),    4'b0001, 5'd0};  // ACC = 00
    vecs[10] = '{op(7, 6, 7, 1),    4'b1100, 5'd0};  // 00-10 = F0, borrow
    vecs[11] = '{op(5, 5, 7, 1),    4'b0110, 5'd0};  // F1
    vecs[12] = '{op(4, 7, 7, 1),    4'b0001, 5'd0};  // 00
    vecs[13] = '{op(1, 7, 7, 1),    4'b0100, 5'd0};  // FF
    vecs[14] = '{op(5, 5, 7, 1),    4'b1001, 5'd0};  // FF+1 wraps, carry
    vecs[15] = '{op(0, 7, 5, 1),    4'b0001, 5'd0};  // try to write ONE
    vecs[16] = '{op(0, 5, 6, 1),    4'b0010, 5'd0};  // ONE still 1
    vecs[17] = '{op(6, 5, 6, 1),    4'b0010, 5'd0};  // TEMP = 2
    vecs[18] = '{op(1, 5, 7, 1),    4'b0100, 5'd0};  // ACC = FF
    vecs[19] = '{op(6, 7, 6, 1),    4'b1001, 5'd0};  // inc FF -> 00, carry
    vecs[20] = '{op(2, 5, 3, 1),    4'b0010, 5'd0};  // A = FF & 01
    vecs[21] = '{op(3, 6, 3, 1),    4'b0100, 5'd0};  // A = FF | 00
    vecs[22] = '{rst_op(),          4'b0000, 5'd0};  // reset mid-sequence
    vecs[23] = '{op(0, 7, 7, 0),    4'b0001, 5'd0};  // ACC back to 0
    vecs[24] = '{op(0, 3, 3, 0),    4'b0001, 5'd0};  // A back to 0
    vecs[25] = '{op(0, 5, 5, 0),    4'b0010, 5'd0};  // ONE = 1
    vecs[26] = '{op(4, 7, 7, 1),    4'b0010, 5'd0};  // enaf off below: hold
    vecs[26].c.enaf = 1'b0;

    foreach (vecs[i]) begin
      run(vecs[i].c);
      check_out($sformatf("vec%0d", i), vecs[i].exp_cnpz, vecs[i].exp_ir);
    end

    // Memory round trip through MAR/MDR/IR.
    load_acc(8'h10);
    c = op(0, 7, 0, 0); c.enaf = 1'b0; c.mar_en = 1'b1; run(c);
    load_acc(8'hA5);
    c = op(0, 7, 0, 0); c.enaf = 1'b0; c.mdr_en = 1'b1; c.wr_rdn = 1'b1; run(c);
    c = '0; c.wr_rdn = 1'b1; run(c);
    c = '0; c.ir_en = 1'b1; run(c);
    check_out("ir_from_mdr", {m_c, m_n, m_p, m_z}, 5'b10100);
    c = op(4, 7, 0, 0); c.enaf = 1'b0; c.mdr_en = 1'b1; c.wr_rdn = 1'b1; run(c);
    c = '0; c.ir_en = 1'b1; run(c);
    check_out("mdr_cleared", {m_c, m_n, m_p, m_z}, 5'b00000);
    c = '0; c.mdr_en = 1'b1; run(c);
    c = '0; c.ir_en = 1'b1; run(c);
    check_out("mem_readback", {m_c, m_n, m_p, m_z}, 5'b10100);

    // sclr clears flags and IR but leaves the bank alone.
    run(op(5, 7, 6, 0));
    check_out("flags_set", 4'b1010, 5'b10100);
    c = '0; c.sclr = 1'b1; run(c);
    check_out("sclr", 4'b0000, 5'd0);
    run(op(0, 7, 7, 0));
    check_out("bank_after_sclr", 4'b0100, 5'd0);

    // Shifter on Y = 0x81.
    load_acc(8'h81);
    c = op(0, 7, 7, 0); c.shamt = 2'b10; run(c);
    check_out("srl_81", SHIFTER_EN ? 4'b1010 : 4'b0100, 5'd0);
    c = op(0, 7, 7, 0); c.shamt = 2'b01; run(c);
    check_out("sll_81", SHIFTER_EN ? 4'b1010 : 4'b0100, 5'd0);
    c = op(0, 7, 7, 0); c.shamt = 2'b11; run(c);
    check_out("pass_81", 4'b0100, 5'd0);

    // Fill memory with mem[i] = i so random reads hit known data.
    run(op(4, 7, 6, 1));
    for (int i = 0; i < 256; i++) begin
      c = op(0, 6, 0, 0); c.enaf = 1'b0; c.mar_en = 1'b1; c.mdr_en = 1'b1; c.wr_rdn = 1'b1; run(c);
      c = op(6, 6, 6, 1); c.enaf = 1'b0; c.wr_rdn = 1'b1; run(c);
    end
    check_model("mem_fill");

    // Random micro-ops against the model.
    for (int k = 0; k < 3000; k++) begin
      c = '0;
      if ($urandom_range(0, 149) == 0) begin
        c.rst = 1'b1;
      end else if ($urandom_range(0, 99) == 0) begin
        c.sclr = 1'b1;
      end else begin
        c.selop = 3'($urandom_range(0, 7));
        c.shamt = 2'($urandom_range(0, 3));
        c.busb = 3'($urandom_range(0, 7));
        c.busc = 3'($urandom_range(0, 7));
        c.bank_wr_en = 1'($urandom_range(0, 1));
        c.enaf = 1'($urandom_range(0, 1));
        c.mdr_alu_n = ($urandom_range(0, 3) == 0);
        c.mar_en = 1'($urandom_range(0, 1));
        c.mdr_en = 1'($urandom_range(0, 1));
        c.wr_rdn = ($urandom_range(0, 3) == 0);
        c.ir_en = 1'($urandom_range(0, 1));
      end
      run(c);
      check_model("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pdua.md
# pdua

Datapath of the PDUA teaching processor: register bank, ALU with optional shifter, and condition flags, plus MAR, MDR, IR and an internal data memory. It executes one micro-operation per clock, driven entirely by control inputs from an external microsequencer, and returns the opcode field of the IR.

## Interface
- MAX_WIDTH, 8, data/bus/register width.
- ADDR_WIDTH, 3, register-bank address width (2^ADDR_WIDTH registers).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_rdn  in  1  memory direction: 1 = write, 0 = read.
- enaf  in  1  flag-register load enable.
- selop  in  3  ALU operation select.
- shamt  in  2  shifter control.
- C, N, P, Z  out  1 each  registered carry, negative, parity and zero flags.
- bank_wr_en  in  1  register-bank write enable.
- BusB_addr  in  ADDR_WIDTH  register driven onto bus B.
- BusC_addr  in  ADDR_WIDTH  destination register for bus C.
- sclr  in  1  synchronous clear of MAR, MDR, IR and flags.
- ir_en, mar_en, mdr_en  in  1 each  load enables.
- mdr_alu_n  in  1  bus C source: 1 = MDR, 0 = ALU/shifter.
- out_IR  out  5  IR[MAX_WIDTH-1:MAX_WIDTH-5] (opcode).

## Operation
- Register map: 0 PC, 1 SP, 2 DPTR, 3 A, 4 VI, 5 ONE (read-only, always 1; writes ignored), 6 TEMP, 7 ACC.
- Bus A is always ACC (reg 7). Bus B is bank[BusB_addr]. Both are combinational reads.
- ALU result Y, where a = ACC and b = bus B:
  - 000: Y = b.
  - 001: Y = ~a.
  - 010: Y = a & b.
  - 011: Y = a | b.
  - 100: Y = a ^ b.
  - 101: Y = a + b; carry = carry-out.
  - 110: Y = b + 1; carry = carry-out.
  - 111: Y = a - b; carry = borrow.
  - All other ops: carry = 0.
- Shifter acts on Y:
  - 00: pass.
  - 01: shift left logical 1; carry = Y[MSB].
  - 10: shift right logical 1; carry = Y[0].
  - 11: pass.
- Bus C = MDR when mdr_alu_n = 1, otherwise the shifter output.
- bank_wr_en: bank[BusC_addr] <= bus C.
- enaf loads the flags from the shifter output S:
  - C = final carry.
  - N = S[MSB].
  - Z = (S == 0).
  - P = ^S (odd parity).
- mar_en: MAR <= bus C.
- Memory is 2^MAX_WIDTH words, internal, addressed by MAR.
  - wr_rdn = 1: mem[MAR] <= MDR.
  - mdr_en with wr_rdn = 0: MDR <= mem[MAR].
  - mdr_en with wr_rdn = 1: MDR <= bus C; memory receives the old MDR.
- ir_en: IR <= MDR.
- Precedence: rst, then sclr, then load enables.

## Timing
- Reset: all bank registers 0 except ONE = 1. MAR, MDR and IR are 0; memory contents are unchanged. C = N = P = Z = 0, out_IR = 0.
- sclr clears MAR, MDR, IR and flags in one cycle. The bank is untouched.
- All writes take effect at the edge that samples the enable. Reads and bus C are combinational, so a write's result is visible the following cycle.
- Read-modify-write of ACC in one cycle uses the pre-edge ACC value.
- Memory read latency is 1 cycle (MAR to MDR). IR is loaded from MDR one cycle later.
- Arithmetic wraps modulo 2^MAX_WIDTH.
- BusB_addr == BusC_addr in the same cycle reads the old value.

## Configuration
- PDUA_SHIFTER_EN defined: the shifter is present as above.
- PDUA_SHIFTER_EN undefined: shamt is ignored, S = Y, and carry comes from the ALU only.

## Test plan
- Reset, then selop = 001, shamt = 00, BusB = BusC = 7, bank_wr_en = 1, enaf = 1 for one edge -> ACC = 0xFF, N = 1, Z = 0, P = 0, C = 0. A second edge -> ACC = 0x00, Z = 1, N = 0.
- Load ACC = 0xF0 (via selop 000 from reg 5 and shifts, or MDR), then selop 101 with BusB = 5 (ONE) -> ACC = 0xF1. From ACC = 0xFF, the same op gives 0x00 with C = 1, Z = 1.
- Write to reg 5 -> reg 5 still reads 1. rst mid-sequence -> all bank registers 0 except ONE = 1, flags 0.
- MAR <= 0x10, MDR <= 0xA5 (mdr_en, wr_rdn = 1), then wr_rdn = 1 -> mem[0x10] = 0xA5. Clear MDR, then mdr_en with wr_rdn = 0 -> MDR = 0xA5. ir_en -> out_IR = 5'b10100.
- shamt = 10 on Y = 0x81 -> S = 0x40, C = 1. shamt = 01 -> S = 0x02, C = 1. Without PDUA_SHIFTER_EN -> S = 0x81.
- sclr with flags set and IR loaded -> flags 0, out_IR = 0, bank unchanged.
